sync_gray_pointer: RTL and testbench

Parametrised gray-code pointer synchroniser for the async FIFO. It is the next generation of the two-flop write-to-read synchroniser. It carries a gray pointer from the foreign clock domain into the local domain through a configurable number of flop stages. It then produces a registered binary copy, the pointer advance since the previous cycle, and a change pulse. An optional sticky gray-violation detector can be compiled in.

---
 rtl/sync_gray_pointer.sv | 136 +++++++++++++
 tb/tb_sync_gray_pointer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sync_gray_pointer.sv
// sync_gray_pointer
// Brings a gray-coded FIFO pointer from the foreign (write) clock domain into
// the local read_clk domain through SYNC_STAGES flops. It then provides a
// registered binary copy, the pointer advance since the previous cycle and a
// change flag.
// Optional feature macro: GRAY_CHECK_EN compiles in a sticky gray-violation
// detector (gray_error / clear_error). Without it gray_error is tied low.
module sync_gray_pointer #(
  parameter int ADDRESS_SIZE = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  read_clk,
  input  logic                  read_reset,
  input  logic [ADDRESS_SIZE:0] write_pointer,
  input  logic                  clear_error,
  output logic [ADDRESS_SIZE:0] read_to_write_pointer,
  output logic [ADDRESS_SIZE:0] read_to_write_pointer_bin,
  output logic [ADDRESS_SIZE:0] pointer_advance,
  output logic                  pointer_changed,
  output logic                  gray_error
);

  localparam int W = ADDRESS_SIZE + 1;

  // A chain shorter than two flops is not a synchroniser; deeper than four is not supported.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_depth_check
    $error("sync_gray_pointer: SYNC_STAGES must be in the range 2..4");
  end

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] gray);
    logic [W-1:0] bin;
    bin[W-1] = gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] bin_d;
  logic [W-1:0] bin_q;
  logic [W-1:0] advance_d;
  logic [W-1:0] advance_q;
  logic         changed_d;
  logic         changed_q;

  // Shift the foreign pointer through the synchroniser chain.
  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {W{1'b0}};
      end
    end else begin
      sync_q[0] <= write_pointer;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign read_to_write_pointer = sync_q[SYNC_STAGES-1];

  // Decode the synchronised pointer and measure its advance against the held binary value.
  always_comb begin
    bin_d     = gray_to_bin(read_to_write_pointer);
    advance_d = bin_d - bin_q;
    changed_d = (advance_d != {W{1'b0}});
  end

  // Register binary value, advance and change flag together so they stay aligned.
  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      bin_q     <= {W{1'b0}};
      advance_q <= {W{1'b0}};
      changed_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      advance_q <= advance_d;
      changed_q <= changed_d;
    end
  end

  assign read_to_write_pointer_bin = bin_q;
  assign pointer_advance           = advance_q;
  assign pointer_changed           = changed_q;

`ifdef GRAY_CHECK_EN
  // True when two gray values differ in more than one bit position.
  function automatic logic multi_bit_change(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] diff;
    int unsigned  ones;
    diff = a ^ b;
    ones = 32'd0;
    for (int i = 0; i < W; i++) begin
      ones = ones + {31'd0, diff[i]};
    end
    return (ones > 32'd1);
  endfunction

  logic [W-1:0] gray_prev_q;
  logic         violation_s;
  logic         error_d;
  logic         error_q;

  // A fresh violation takes priority over a clear request; otherwise the flag is sticky.
  always_comb begin
    violation_s = multi_bit_change(read_to_write_pointer, gray_prev_q);
    if (violation_s) begin
      error_d = 1'b1;
    end else if (clear_error) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end
  end

  // Remember last cycle's synchronised gray value and hold the sticky flag.
  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      gray_prev_q <= {W{1'b0}};
      error_q     <= 1'b0;
    end else begin
      gray_prev_q <= read_to_write_pointer;
      error_q     <= error_d;
    end
  end

  assign gray_error = error_q;
`else
  logic unused_clear_error;
  assign unused_clear_error = clear_error;
  assign gray_error         = 1'b0;
`endif

endmodule

// File: tb/tb_sync_gray_pointer.sv
// Self-checking bench for sync_gray_pointer (ADDRESS_SIZE=3, so W=4).
// dut2 uses SYNC_STAGES=2, and dut3 uses SYNC_STAGES=3 for the depth test.
module tb_sync_gray_pointer;

  logic       read_clk = 1'b0;
  logic       read_reset;
  logic       clear_error;
  logic [3:0] write_pointer;

  logic [3:0] gray2, bin2, adv2;
  logic       chg2, err2;
  logic [3:0] gray3, bin3, adv3;
  logic       chg3, err3;

  int checks = 0;
  int errors = 0;

`ifdef GRAY_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  always #5 read_clk = ~read_clk;

  sync_gray_pointer #(.ADDRESS_SIZE(3), .SYNC_STAGES(2)) dut2 (
    .read_clk                  (read_clk),
    .read_reset                (read_reset),
    .write_pointer             (write_pointer),
    .clear_error               (clear_error),
    .read_to_write_pointer     (gray2),
    .read_to_write_pointer_bin (bin2),
    .pointer_advance           (adv2),
    .pointer_changed           (chg2),
    .gray_error                (err2)
  );

  sync_gray_pointer #(.ADDRESS_SIZE(3), .SYNC_STAGES(3)) dut3 (
    .read_clk                  (read_clk),
    .read_reset                (read_reset),
    .write_pointer             (write_pointer),
    .clear_error               (clear_error),
    .read_to_write_pointer     (gray3),
    .read_to_write_pointer_bin (bin3),
    .pointer_advance           (adv3),
    .pointer_changed           (chg3),
    .gray_error                (err3)
  );

  typedef struct {
    logic [3:0] wp;
    logic       clr;
    logic [3:0] gray;
    logic [3:0] bin;
    logic [3:0] adv;
    logic       chg;
    logic       err;   // expectation when the gray checker is compiled in
  } vec_t;

  vec_t vecs [33];
  vec_t sb_q [$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dut2 gray"}, gray2, 4'd0);
    check({tag, " dut2 bin"},  bin2,  4'd0);
    check({tag, " dut2 adv"},  adv2,  4'd0);
    check({tag, " dut2 chg"},  {3'b000, chg2}, 4'd0);
    check({tag, " dut2 err"},  {3'b000, err2}, 4'd0);
    check({tag, " dut3 gray"}, gray3, 4'd0);
    check({tag, " dut3 bin"},  bin3,  4'd0);
    check({tag, " dut3 adv"},  adv3,  4'd0);
    check({tag, " dut3 chg"},  {3'b000, chg3}, 4'd0);
    check({tag, " dut3 err"},  {3'b000, err3}, 4'd0);
  endtask

  task automatic tick();
    @(posedge read_clk);
    @(negedge read_clk);
  endtask

  initial begin
    vec_t e;

    // Expected dut2 outputs after the edge that samples each row's inputs.
    //          wp      clr   gray    bin    adv    chg   err
    vecs[0]  = '{4'b0110, 1'b0, 4'b0000, 4'd0,  4'd0,  1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 1'b0, 4'b0110, 4'd0,  4'd0,  1'b0, 1'b0};
    vecs[2]  = '{4'b0110, 1'b0, 4'b0110, 4'd4,  4'd4,  1'b1, 1'b1};
    vecs[3]  = '{4'b0110, 1'b1, 4'b0110, 4'd4,  4'd0,  1'b0, 1'b0};
    vecs[4]  = '{4'b0110, 1'b0, 4'b0110, 4'd4,  4'd0,  1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0110, 4'd4,  4'd0,  1'b0, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 4'd4,  4'd0,  1'b0, 1'b0};
    vecs[7]  = '{4'b0001, 1'b0, 4'b0000, 4'd0,  4'd12, 1'b1, 1'b1};
    vecs[8]  = '{4'b0011, 1'b0, 4'b0001, 4'd0,  4'd0,  1'b0, 1'b1};
    vecs[9]  = '{4'b0010, 1'b0, 4'b0011, 4'd1,  4'd1,  1'b1, 1'b1};
    vecs[10] = '{4'b0110, 1'b0, 4'b0010, 4'd2,  4'd1,  1'b1, 1'b1};
    vecs[11] = '{4'b0110, 1'b0, 4'b0110, 4'd3,  4'd1,  1'b1, 1'b1};
    vecs[12] = '{4'b0110, 1'b0, 4'b0110, 4'd4,  4'd1,  1'b1, 1'b1};
    vecs[13] = '{4'b0110, 1'b1, 4'b0110, 4'd4,  4'd0,  1'b0, 1'b0};
    vecs[14] = '{4'b0110, 1'b0, 4'b0110, 4'd4,  4'd0,  1'b0, 1'b0};
    vecs[15] = '{4'b1000, 1'b0, 4'b0110, 4'd4,  4'd0,  1'b0, 1'b0};
    vecs[16] = '{4'b1000, 1'b0, 4'b1000, 4'd4,  4'd0,  1'b0, 1'b0};
    vecs[17] = '{4'b0000, 1'b0, 4'b1000, 4'd15, 4'd11, 1'b1, 1'b1};
    vecs[18] = '{4'b0000, 1'b0, 4'b0000, 4'd15, 4'd0,  1'b0, 1'b1};
    vecs[19] = '{4'b0000, 1'b0, 4'b0000, 4'd0,  4'd1,  1'b1, 1'b1};
    vecs[20] = '{4'b0000, 1'b1, 4'b0000, 4'd0,  4'd0,  1'b0, 1'b0};
    vecs[21] = '{4'b0000, 1'b0, 4'b0000, 4'd0,  4'd0,  1'b0, 1'b0};
    vecs[22] = '{4'b0011, 1'b0, 4'b0000, 4'd0,  4'd0,  1'b0, 1'b0};
    vecs[23] = '{4'b0011, 1'b0, 4'b0011, 4'd0,  4'd0,  1'b0, 1'b0};
    vecs[24] = '{4'b0011, 1'b0, 4'b0011, 4'd2,  4'd2,  1'b1, 1'b1};
    vecs[25] = '{4'b0011, 1'b0, 4'b0011, 4'd2,  4'd0,  1'b0, 1'b1};
    vecs[26] = '{4'b0011, 1'b1, 4'b0011, 4'd2,  4'd0,  1'b0, 1'b0};
    vecs[27] = '{4'b0011, 1'b0, 4'b0011, 4'd2,  4'd0,  1'b0, 1'b0};
    vecs[28] = '{4'b0000, 1'b0, 4'b0011, 4'd2,  4'd0,  1'b0, 1'b0};
    vecs[29] = '{4'b0000, 1'b0, 4'b0000, 4'd2,  4'd0,  1'b0, 1'b0};
    vecs[30] = '{4'b0000, 1'b1, 4'b0000, 4'd0,  4'd14, 1'b1, 1'b1};
    vecs[31] = '{4'b0000, 1'b1, 4'b0000, 4'd0,  4'd0,  1'b0, 1'b0};
    vecs[32] = '{4'b0000, 1'b0, 4'b0000, 4'd0,  4'd0,  1'b0, 1'b0};

    // Reset held over several edges with a nonzero pointer on the input.
    read_reset    = 1'b1;
    clear_error   = 1'b0;
    write_pointer = 4'b0110;
    repeat (3) tick();
    check_all_zero("reset");
    read_reset = 1'b0;

    // Table: latency, counting, wrap-around, gray violations and clear priority.
    for (int i = 0; i < 33; i++) begin
      write_pointer = vecs[i].wp;
      clear_error   = vecs[i].clr;
      sb_q.push_back(vecs[i]);
      tick();
      e = sb_q.pop_front();
      check($sformatf("row%0d gray", i + 1), gray2, e.gray);
      check($sformatf("row%0d bin", i + 1),  bin2,  e.bin);
      check($sformatf("row%0d adv", i + 1),  adv2,  e.adv);
      check($sformatf("row%0d chg", i + 1),  {3'b000, chg2}, {3'b000, e.chg});
      check($sformatf("row%0d err", i + 1),  {3'b000, err2}, {3'b000, e.err & CHK});
    end
    clear_error = 1'b0;

    // Count up to bin 5 (gray 0111), then hit reset between clock edges.
    write_pointer = 4'b0111;
    repeat (4) tick();
    check("pre-reset bin", bin2, 4'd5);
    @(posedge read_clk);
    #2 read_reset = 1'b1;
    #1 check_all_zero("async reset");
    tick();
    read_reset = 1'b0;
    tick();
    tick();
    check("post-reset gray", gray2, 4'b0111);
    check("post-reset bin early", bin2, 4'd0);
    tick();
    check("post-reset bin", bin2, 4'd5);
    check("post-reset adv", adv2, 4'd5);
    check("post-reset chg", {3'b000, chg2}, 4'd1);
    check("post-reset err", {3'b000, err2}, {3'b000, CHK});
    check("post-reset dut3 gray", gray3, 4'b0111);
    check("post-reset dut3 bin", bin3, 4'd0);

    // Depth: step 0000 -> 0001 and compare the two synchroniser depths.
    write_pointer = 4'b0000;
    repeat (6) tick();
    write_pointer = 4'b0001;
    tick();
    tick();
    check("depth dut2 gray@2", gray2, 4'b0001);
    check("depth dut3 gray@2", gray3, 4'b0000);
    tick();
    check("depth dut3 gray@3", gray3, 4'b0001);
    check("depth dut3 bin@3", bin3, 4'd0);
    tick();
    check("depth dut3 bin@4", bin3, 4'd1);
    check("depth dut3 adv@4", adv3, 4'd1);
    check("depth dut3 chg@4", {3'b000, chg3}, 4'd1);
    tick();
    check("depth dut3 chg@5", {3'b000, chg3}, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
